// File: rtl/multi_ch_timer.sv
// Multi-channel tick timer: CH_NUM independent one-shot/periodic channels driven by one
// shared prescaled tick, each with its own terminal count latched at start or reload.
// Expiry is reported as a pulse, a sticky pending flag and one masked interrupt line.
module multi_ch_timer #(
  parameter int unsigned CH_NUM = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      tick_i,
  input  logic [CH_NUM-1:0]         cnt_en_i,
  input  logic [CH_NUM-1:0]         mode_i,
  input  logic [CH_NUM*CNT_W-1:0]   cnt_size_i,
  input  logic [CH_NUM-1:0]         irq_mask_i,
  input  logic [CH_NUM-1:0]         irq_clr_i,
  output logic [CH_NUM-1:0]         expire_o,
  output logic [CH_NUM-1:0]         timeout_o,
  output logic [CH_NUM-1:0]         pend_o,
  output logic                      irq_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CH_NUM-1:0] expiry;
  logic              irq_q;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    state_e           state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] shadow_q;
    logic [CNT_W-1:0] size;
    logic             expire_q;
    logic             timeout_q;
    logic             pend_q;

    assign size = cnt_size_i[g*CNT_W +: CNT_W];

    // A zero-size channel fires on its first RUN edge; otherwise on the tick that
    // would make count reach shadow. Dropping cnt_en suppresses expiry.
    assign expiry[g] = (state_q == StRun) && cnt_en_i[g] &&
                       ((shadow_q == '0) || (tick_i && (count_q == shadow_q - CntOne)));

    // Channel FSM with count, shadow and registered status outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        state_q   <= StIdle;
        count_q   <= '0;
        shadow_q  <= '0;
        expire_q  <= 1'b0;
        timeout_q <= 1'b0;
        pend_q    <= 1'b0;
      end else begin
        expire_q <= expiry[g];
        // Set wins over a same-edge clear.
        pend_q   <= expiry[g] | (pend_q & ~irq_clr_i[g]);
        case (state_q)
          StIdle: begin
            count_q <= '0;
            if (cnt_en_i[g]) begin
              state_q  <= StRun;
              shadow_q <= size;
            end
          end
          StRun: begin
            if (!cnt_en_i[g]) begin
              state_q <= StIdle;
              count_q <= '0;
            end else if (expiry[g]) begin
              if (mode_i[g]) begin
                count_q  <= '0;
                shadow_q <= size;
              end else begin
                state_q   <= StDone;
                count_q   <= shadow_q;
                timeout_q <= 1'b1;
              end
            end else if (tick_i) begin
              count_q <= count_q + CntOne;
            end
          end
          StDone: begin
            if (!cnt_en_i[g]) begin
              state_q   <= StIdle;
              count_q   <= '0;
              timeout_q <= 1'b0;
            end
          end
          default: begin
            state_q   <= StIdle;
            count_q   <= '0;
            timeout_q <= 1'b0;
          end
        endcase
      end
    end

    assign expire_o[g]  = expire_q;
    assign timeout_o[g] = timeout_q;
    assign pend_o[g]    = pend_q;
  end

  // Interrupt is the masked OR of the pending flags, one cycle behind them.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(pend_o & irq_mask_i);
    end
  end

  assign irq_o = irq_q;

endmodule

// File: tb/tb_multi_ch_timer.sv
// Scoreboard bench for multi_ch_timer: directed scenarios plus random traffic, checked
// against a remaining-ticks reference model evaluated once per clock edge.
module tb_multi_ch_timer;
  localparam int unsigned CH = 4;
  localparam int unsigned W  = 4;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          tick      = 1'b0;
  logic [CH-1:0] en        = '0;
  logic [CH-1:0] mode      = '0;
  logic [CH-1:0] mask      = '0;
  logic [CH-1:0] clr       = '0;
  logic [CH*W-1:0] size    = '0;
  logic [CH-1:0] expire;
  logic [CH-1:0] timeout;
  logic [CH-1:0] pend;
  logic          irq;

  // Next values requested by the stimulus; applied to the DUT at a falling edge.
  logic [CH-1:0]   n_en   = '0;
  logic [CH-1:0]   n_mode = '0;
  logic [CH-1:0]   n_mask = '0;
  logic [CH*W-1:0] n_size = '0;

  always #5 sys_clk = ~sys_clk;

  multi_ch_timer #(.CH_NUM(CH), .CNT_W(W)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .tick_i     (tick),
    .cnt_en_i   (en),
    .mode_i     (mode),
    .cnt_size_i (size),
    .irq_mask_i (mask),
    .irq_clr_i  (clr),
    .expire_o   (expire),
    .timeout_o  (timeout),
    .pend_o     (pend),
    .irq_o      (irq)
  );

  typedef struct packed {
    logic [CH-1:0] e;
    logic [CH-1:0] t;
    logic [CH-1:0] p;
    logic          i;
  } out_t;

  out_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_n   = 0;

  // Reference model: phase 0 idle, 1 running, 2 done; rem = ticks still needed.
  int            m_ph [CH];
  int            m_rem[CH];
  int            m_shd[CH];
  logic [CH-1:0] m_pend;

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_ph[c]  = 0;
      m_rem[c] = 0;
      m_shd[c] = 0;
    end
    m_pend = '0;
  endfunction

  // Drive inputs now and push the outputs expected after the next rising edge.
  task automatic apply(input logic tk, input logic [CH-1:0] clr_v);
    out_t o;
    logic [CH-1:0] fire;
    en = n_en; mode = n_mode; mask = n_mask; size = n_size; tick = tk; clr = clr_v;
    o.i  = |(m_pend & mask);
    fire = '0;
    for (int c = 0; c < CH; c++) begin
      int sz;
      sz = int'(size[c*W +: W]);
      if (m_ph[c] == 0) begin
        if (en[c]) begin
          m_ph[c] = 1; m_shd[c] = sz; m_rem[c] = sz;
        end
      end else if (m_ph[c] == 1) begin
        if (!en[c]) begin
          m_ph[c] = 0;
        end else if (m_shd[c] == 0 || (tk && m_rem[c] == 1)) begin
          fire[c] = 1'b1;
          if (mode[c]) begin
            m_shd[c] = sz; m_rem[c] = sz;
          end else begin
            m_ph[c] = 2;
          end
        end else if (tk) begin
          m_rem[c] = m_rem[c] - 1;
        end
      end else begin
        if (!en[c]) m_ph[c] = 0;
      end
      o.t[c] = (m_ph[c] == 2);
    end
    m_pend = fire | (m_pend & ~clr_v);
    o.e = fire;
    o.p = m_pend;
    exp_q.push_back(o);
  endtask

  task automatic cyc(input logic tk, input logic [CH-1:0] clr_v);
    @(negedge sys_clk);
    apply(tk, clr_v);
  endtask

  task automatic set_size(input int c, input int v);
    n_size[c*W +: W] = W'(v);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({expire, timeout, pend, irq} !== '0) begin
      failures++;
      $display("FAIL %s: got exp=%b tmo=%b pend=%b irq=%b, required all zero",
               name, expire, timeout, pend, irq);
    end
  endtask

  // Asynchronous reset between clock edges, then resume with the model cleared.
  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    #1;
    sys_rst_n = 1'b1;
    model_reset();
    apply(1'b0, '0);
  endtask

  // Monitor: compare every cycle that has an expectation queued.
  always begin
    out_t got, req;
    @(posedge sys_clk);
    #1;
    edge_n++;
    if (exp_q.size() > 0) begin
      req = exp_q.pop_front();
      got = '{e: expire, t: timeout, p: pend, i: irq};
      checks++;
      if (got !== req) begin
        failures++;
        $display("FAIL outputs edge=%0d: got exp=%b tmo=%b pend=%b irq=%b, required exp=%b tmo=%b pend=%b irq=%b",
                 edge_n, got.e, got.t, got.p, got.i, req.e, req.t, req.p, req.i);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge sys_clk);
    #2;
    check_zero("reset_state");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    n_mask = '1;

    // One-shot CH0, size 3, tick every cycle; then drop enable.
    set_size(0, 3); n_en = 4'b0001;
    repeat (8) cyc(1'b1, '0);
    n_en = '0;
    repeat (3) cyc(1'b1, '0);
    cyc(1'b0, 4'b0001);

    // Periodic CH1, size 2, tick every 4th cycle; resize to 5 mid-period.
    set_size(1, 2); n_mode = 4'b0010; n_en = 4'b0010;
    for (int i = 0; i < 22; i++) cyc(i % 4 == 3, '0);
    set_size(1, 5);
    for (int i = 0; i < 44; i++) cyc(i % 4 == 1, '0);
    n_en = '0;
    repeat (2) cyc(1'b0, 4'b0010);

    // Zero size CH2: one-shot then periodic, no ticks.
    set_size(2, 0); n_mode = '0; n_en = 4'b0100;
    repeat (4) cyc(1'b0, '0);
    n_en = '0;
    cyc(1'b0, '0);
    n_mode = 4'b0100; n_en = 4'b0100;
    repeat (5) cyc(1'b0, '0);
    n_en = '0;
    repeat (2) cyc(1'b0, 4'b0100);

    // Abort CH0 at count 2 of 3, then re-enable for a full run.
    n_mode = '0; set_size(0, 3); n_en = 4'b0001;
    cyc(1'b0, '0); cyc(1'b1, '0); cyc(1'b1, '0);
    n_en = '0;
    cyc(1'b1, '0);
    n_en = 4'b0001;
    repeat (6) cyc(1'b1, '0);
    n_en = '0;
    cyc(1'b1, '0);

    // Clear on the same edge as expiry (periodic size 1), then clear alone.
    set_size(0, 1); n_mode = 4'b0001; n_en = 4'b0001;
    cyc(1'b0, '0);
    repeat (4) cyc(1'b1, 4'b0001);
    n_en = '0;
    cyc(1'b0, '0);
    cyc(1'b0, 4'b0001);
    repeat (2) cyc(1'b0, '0);

    // Masked channel: pend set but irq stays low, then unmask.
    n_mode = '0; n_mask = 4'b0111; set_size(3, 2); n_en = 4'b1000;
    repeat (6) cyc(1'b1, '0);
    n_mask = '1;
    repeat (2) cyc(1'b1, '0);
    n_en = '0;
    cyc(1'b0, 4'b1000);

    // Maximum terminal count, continuous tick: no wrap.
    set_size(0, 15); n_en = 4'b0001;
    repeat (20) cyc(1'b1, '0);
    n_en = '0;
    cyc(1'b0, 4'b0001);

    // Reset mid-run with several channels active.
    n_size = {4'd4, 4'd1, 4'd9, 4'd3}; n_mode = 4'b0101; n_en = '1;
    repeat (6) cyc(1'b1, '0);
    do_reset();
    n_en = '0;
    cyc(1'b0, '0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [CH-1:0] rc;
      rc = '0;
      for (int c = 0; c < CH; c++) begin
        if ($urandom % 16 == 0) n_en[c] = ~n_en[c];
        if ($urandom % 32 == 0) n_mode[c] = ~n_mode[c];
        if ($urandom % 8 == 0) set_size(c, ($urandom % 4 == 0) ? $urandom % 16 : $urandom % 5);
        if ($urandom % 64 == 0) n_mask[c] = ~n_mask[c];
        rc[c] = ($urandom % 8 == 0);
      end
      if ($urandom % 700 == 0) do_reset();
      else cyc(1'($urandom % 2), rc);
    end

    @(posedge sys_clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_ch_timer.md
# multi_ch_timer

Parametrised multi-channel tick timer, the successor to the single 11-bit ms timer. It runs CH_NUM independent channels off one shared prescaled tick. Each channel is either one-shot or periodic and has its own width-generic terminal count, which is latched at start. Expiry is reported three ways: per-channel pulses, per-channel sticky pending bits, and one masked interrupt line for the CPLD I2C register front end.

## Interface
- CH_NUM, 4, number of independent channels (1..16)
- CNT_W, 16, counter and terminal-count width in bits (2..32)
- sys_clk  input  1  system clock; all logic rising-edge
- sys_rst_n  input  1  reset, asynchronous, active-low
- tick  input  1  shared prescaled count strobe (e.g. 1 ms), one sys_clk wide
- cnt_en  input  CH_NUM  per-channel enable; low holds channel in IDLE
- mode  input  CH_NUM  per-channel mode: 0 = one-shot, 1 = periodic
- cnt_size  input  CH_NUM*CNT_W  terminal counts; channel n uses bits [n*CNT_W +: CNT_W]
- irq_mask  input  CH_NUM  1 = channel contributes to irq
- irq_clr  input  CH_NUM  one-cycle pulse clears the matching pend bit
- expire  output  CH_NUM  one-cycle pulse per channel expiry
- timeout  output  CH_NUM  level; high while a one-shot channel is in DONE
- pend  output  CH_NUM  sticky expiry flags
- irq  output  1  OR of (pend & irq_mask), registered

## Operation
- Each channel has three states (IDLE, RUN, DONE), a CNT_W-bit count, and a CNT_W-bit shadow of cnt_size.
- IDLE: count = 0.
  - At an edge with cnt_en = 1: go to RUN; count <= 0; shadow <= cnt_size.
- RUN:
  - cnt_en = 0 at the edge: go to IDLE and clear count. No expire is generated. This takes priority over everything else.
  - shadow == 0: the channel expires at the first edge in RUN. tick is ignored.
  - Otherwise, a tick = 1 at the edge gives count <= count + 1. When count == shadow − 1 with tick = 1, the channel expires at that edge.
  - Expiry in one-shot mode: go to DONE; count <= shadow.
  - Expiry in periodic mode: stay in RUN; count <= 0; shadow <= cnt_size (reload).
- DONE: count is frozen at shadow. tick is ignored. At an edge with cnt_en = 0, go to IDLE. Re-arming requires cnt_en to be low for at least one cycle.
- cnt_size changes during RUN or DONE take effect only at the next start or periodic reload.
- mode is sampled at each expiry edge.
- The count never wraps: the maximum terminal count is 2^CNT_W − 1 ticks. Arithmetic is unsigned, CNT_W bits.
- pend[n]:
  - Set at an expiry edge of channel n.
  - Cleared at an edge with irq_clr[n] = 1 and no expiry on that edge.
  - Expiry and clear on the same edge: set wins.
  - cnt_en does not affect pend.

## Timing
- Reset values: all states IDLE, all counts and shadows 0, expire = 0, timeout = 0, pend = 0, irq = 0.
- All outputs are registered.
- expire[n]: high for exactly the one cycle following the expiry edge.
- timeout[n]: high from the cycle following the expiry edge until the cycle following the edge where cnt_en is seen low.
- irq: follows pend & irq_mask with one further cycle of latency, i.e. two cycles after the expiry edge.
- Latency from start: an enable seen at edge E0 with size S > 0 and tick high every cycle expires at edge E0+S. expire is high in cycle E0+S → E0+S+1.
- Periodic period: S ticks. With continuous ticks, expire pulses every S cycles. With S = 0, expire pulses every cycle.
- Reset asserted mid-operation clears every channel immediately, without waiting for a clock. No expire is generated.
- Channels are fully independent. Simultaneous expiries on different channels all set their pend bits on the same edge.

## Test plan
- One-shot: CH0, size 3, tick every cycle, cnt_en raised at edge 0 → expire[0] high in cycle 3 only; timeout[0] high from cycle 3; pend[0] = 1; irq = 1 in cycle 4 with mask = 1. Drop cnt_en → timeout[0] = 0 one cycle later.
- Periodic: CH1, size 2, tick every 4th cycle → expire[1] once per 8 cycles, timeout[1] stays 0. Change cnt_size to 5 mid-period → current period stays 2 ticks, next period is 5 ticks.
- Zero size: CH2, size 0, one-shot → expire at the first RUN edge regardless of tick. Same setup in periodic mode → expire every cycle.
- Abort and reset:
  - Drop cnt_en with count = 2 of 3 → no expire, count returns to 0.
  - Re-enable → full 3 ticks required.
  - Assert sys_rst_n low mid-run → all outputs 0 immediately.
- Pending and irq:
  - irq_clr[0] on the same edge as an expiry of CH0 → pend[0] stays 1.
  - irq_clr[0] on a later edge → pend[0] = 0, irq = 0 one cycle later.
  - mask = 0 → irq stays 0 while pend = 1.
- Maximum count: CNT_W = 4, size 15, continuous tick → expire after exactly 15 cycles, no wrap. Parameter sweep with CH_NUM = 1 and CH_NUM = 16.
